// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALUOp/funct3 constants, decoded op set
// and the sequencer state type.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_PASSB
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} exec_state_t;

    function automatic logic is_mul_op(input alu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div_op(input alu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALUOp/funct3/funct7/op5 decode into the execute op set.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7_5,
    input  logic       funct7_0,
    output alu_op_t    op
);

    always_comb begin
        op = OP_ADD;
        case (ALUOp)
            ALUOP_ADD:   op = OP_ADD;
            ALUOP_SUB:   op = OP_SUB;
            ALUOP_PASSB: op = OP_PASSB;
            default: begin
                if (ENABLE_M && op5 && funct7_0) begin
                    case (funct3)
                        F3_MUL:    op = OP_MUL;
                        F3_MULH:   op = OP_MULH;
                        F3_MULHSU: op = OP_MULHSU;
                        F3_MULHU:  op = OP_MULHU;
                        F3_DIV:    op = OP_DIV;
                        F3_DIVU:   op = OP_DIVU;
                        F3_REM:    op = OP_REM;
                        default:   op = OP_REMU;
                    endcase
                end else begin
                    case (funct3)
                        F3_ADDSUB: op = (op5 && funct7_5) ? OP_SUB : OP_ADD;
                        F3_SLL:    op = OP_SLL;
                        F3_SLT:    op = OP_SLT;
                        F3_SLTU:   op = OP_SLTU;
                        F3_XOR:    op = OP_XOR;
                        F3_SR:     op = funct7_5 ? OP_SRA : OP_SRL;
                        F3_OR:     op = OP_OR;
                        default:   op = OP_AND;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle RV32I ops plus iterative shift-add multiply and
// restoring divide behind a valid/ready handshake.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            op5,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt,
    output logic            ltu
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = $clog2(XLEN + 1);

    exec_state_t       state, state_nx;
    alu_op_t           dec_op, op_q;
    logic              accept;
    logic              mul_op, div_op, fast, iter;
    logic              sa, sb, neg, neg_q;
    logic [XLEN-1:0]   ma, mb, md;
    logic [XLEN-1:0]   alu_res, fin_res, qv, rv;
    logic [2*XLEN-1:0] prod, full;
    logic [XLEN-1:0]   quo;
    logic [XLEN:0]     rem, rem_sh, rem_diff, mul_sum;
    logic [CW-1:0]     cnt;
    logic              zero_p, lt_p, ltu_p;
    logic [SHW-1:0]    shamt;

    alu_op_decoder #(.ENABLE_M(ENABLE_M)) u_dec (
        .ALUOp    (ALUOp),
        .funct3   (funct3),
        .op5      (op5),
        .funct7_5 (funct7_5),
        .funct7_0 (funct7_0),
        .op       (dec_op)
    );

    assign in_ready = (state == IDLE) && rst_n;
    assign accept   = in_valid && in_ready;
    assign shamt    = b[SHW-1:0];

    always_comb begin
        mul_op = is_mul_op(dec_op);
        div_op = is_div_op(dec_op);
        sa     = (dec_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a[XLEN-1];
        sb     = (dec_op inside {OP_MULH, OP_DIV, OP_REM}) && b[XLEN-1];
        ma     = sa ? -a : a;
        mb     = sb ? -b : b;
        neg    = (dec_op == OP_REM) ? sa : (sa ^ sb);
        // Zero divisor and MIN/-1 bypass the divider entirely
        fast   = div_op && ((b == '0) ||
                 ((dec_op inside {OP_DIV, OP_REM}) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)));
        iter   = mul_op || (div_op && !fast);
    end

    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_ADD:            alu_res = a + b;
            OP_SUB:            alu_res = a - b;
            OP_SLL:            alu_res = a << shamt;
            OP_SLT:            alu_res = XLEN'($signed(a) < $signed(b));
            OP_SLTU:           alu_res = XLEN'(a < b);
            OP_XOR:            alu_res = a ^ b;
            OP_SRL:            alu_res = a >> shamt;
            OP_SRA:            alu_res = $signed(a) >>> shamt;
            OP_OR:             alu_res = a | b;
            OP_AND:            alu_res = a & b;
            OP_PASSB:          alu_res = b;
            OP_DIV, OP_DIVU:   alu_res = (b == '0) ? '1 : a;
            OP_REM, OP_REMU:   alu_res = (b == '0) ? a : '0;
            default:           alu_res = '0;
        endcase
    end

    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, md} : '0);
        rem_sh   = (rem << 1) | {{XLEN{1'b0}}, quo[XLEN-1]};
        rem_diff = rem_sh - {1'b0, md};
        full     = neg_q ? -prod : prod;
        qv       = neg_q ? -quo : quo;
        rv       = neg_q ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        case (op_q)
            OP_MUL:            fin_res = full[XLEN-1:0];
            OP_DIV, OP_DIVU:   fin_res = qv;
            OP_REM, OP_REMU:   fin_res = rv;
            default:           fin_res = full[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept && iter) state_nx = mul_op ? MUL : DIV;
            MUL, DIV: if (cnt == CW'(1)) state_nx = FIN;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            lt        <= 1'b0;
            ltu       <= 1'b0;
            cnt       <= '0;
            op_q      <= OP_ADD;
            neg_q     <= 1'b0;
            md        <= '0;
            prod      <= '0;
            quo       <= '0;
            rem       <= '0;
            zero_p    <= 1'b0;
            lt_p      <= 1'b0;
            ltu_p     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    op_q   <= dec_op;
                    neg_q  <= neg;
                    zero_p <= (a == b);
                    lt_p   <= $signed(a) < $signed(b);
                    ltu_p  <= a < b;
                    if (iter) begin
                        cnt <= CW'(XLEN);
                        if (mul_op) begin
                            md   <= ma;
                            prod <= {{XLEN{1'b0}}, mb};
                        end else begin
                            md   <= mb;
                            quo  <= ma;
                            rem  <= '0;
                        end
                    end else begin
                        result    <= alu_res;
                        out_valid <= 1'b1;
                        zero      <= (a == b);
                        lt        <= $signed(a) < $signed(b);
                        ltu       <= a < b;
                    end
                end
                MUL: begin
                    prod <= {mul_sum, prod[XLEN-1:1]};
                    cnt  <= cnt - CW'(1);
                end
                DIV: begin
                    quo <= {quo[XLEN-2:0], ~rem_diff[XLEN]};
                    rem <= rem_diff[XLEN] ? rem_sh : rem_diff;
                    cnt <= cnt - CW'(1);
                end
                default: begin
                    result    <= fin_res;
                    out_valid <= 1'b1;
                    zero      <= zero_p;
                    lt        <= lt_p;
                    ltu       <= ltu_p;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute stage replacing the single-cycle ALU decode/ALU pair in the RISC-V core. Decodes ALUOp/funct3/funct7 into the full RV32I integer op set plus the RV32M multiply/divide ops. RV32I ops return a result one cycle after acceptance. M ops run on an iterative shift-add multiplier or restoring divider behind a valid/ready handshake, so the control unit stalls on `in_ready`.

## Interface
- `XLEN`, default 32: operand/result width, ≥ 8.
- `ENABLE_M`, default 1: when 0, M decode is removed and those encodings execute as their RV32I counterparts.

- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, **synchronous, active-low**.
- `in_valid`, input, 1: operation presented.
- `in_ready`, output, 1: unit can accept; equals `state==IDLE && rst_n`.
- `ALUOp`, input, 2: 00 = add (lw/sw/addr), 01 = sub (branch compare), 10 = R/I-type decode, 11 = pass B (lui).
- `funct3`, input, 3: instruction funct3.
- `op5`, input, 1: opcode bit 5 (1 = R-type).
- `funct7_5`, input, 1: instruction bit 30.
- `funct7_0`, input, 1: instruction bit 25 (M select).
- `a`, input, XLEN: operand A.
- `b`, input, XLEN: operand B / immediate.
- `out_valid`, output, 1: one-cycle pulse when `result` is new.
- `result`, output, XLEN: registered result, held until the next completion.
- `zero`, output, 1: registered `(a==b)` of the accepted op.
- `lt`, output, 1: registered signed `a<b`.
- `ltu`, output, 1: registered unsigned `a<b`.

## Operation
- Accept on a rising edge with `in_valid && in_ready`. Operands and decoded op are captured at that edge.
- Decode for ALUOp=10:
  - funct3 000: SUB if `op5&&funct7_5`, else ADD.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRA if `funct7_5`, else SRL. `op5` is ignored for shifts.
  - 110: OR.
  - 111: AND.
- Shift amount is `b[$clog2(XLEN)-1:0]`.
- M op when `ENABLE_M && ALUOp==10 && op5 && funct7_0`. funct3 selects:
  - 000 MUL (low half); 001 MULH (s×s); 010 MULHSU (s×u); 011 MULHU (u×u).
  - 100 DIV; 101 DIVU; 110 REM; 111 REMU.
- Signed M ops: take magnitudes, run unsigned core, negate the result at finish when signs require. REM sign follows the dividend.
- Fast paths, completing like single-cycle ops:
  - Divide by zero: quotient = all ones, remainder = `a`.
  - Signed overflow (`a=-2^(XLEN-1)`, `b=-1`): quotient = `a`, remainder = 0.
- State machine:
  - IDLE: single-cycle op, fast path, or ALUOp≠10 → stay in IDLE; result registered at the accept edge.
  - IDLE → MUL or DIV on an accepted iterative M op; counter loaded with XLEN.
  - MUL/DIV: one iteration per cycle, counter decrements.
  - After the last iteration → FIN: sign fix, register `result`, pulse `out_valid`.
  - FIN → IDLE.
- `zero`/`lt`/`ltu` are updated on every completion from the captured operands.

## Timing
- Reset (`rst_n` low at an edge): state IDLE; `out_valid`, `result`, `zero`, `lt`, `ltu` = 0; counter = 0. Any in-flight M op is discarded with no `out_valid`.
- `in_ready`=0 while `rst_n` is low.
- Single-cycle ops and fast paths:
  - Accepted at edge N → `out_valid`=1 in the cycle after edge N.
  - Throughput is 1 op/cycle, with back-to-back accepts.
- Iterative M ops:
  - Accepted at edge N; iterations at edges N+1..N+XLEN; FIN at edge N+XLEN+1.
  - `out_valid` is high in the cycle following edge N+XLEN+1: latency XLEN+2.
  - `in_ready`=0 from after edge N until back in IDLE. The cycle in which `out_valid` pulses for an M op has `in_ready`=1, so a new op may be accepted in it.
- `in_valid` with `in_ready`=0 is ignored. The upstream holds inputs stable until accepted.
- Multiplier product register: 2·XLEN bits. Divider: XLEN-bit quotient plus (XLEN+1)-bit partial remainder. All add/sub ops wrap modulo 2^XLEN.

## Structure
- Package `alu_pkg`:
  - ALUOp encodings (`ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_RTYPE`, `ALUOP_PASSB`).
  - funct3 constants.
  - `alu_op_t` enum (ADD…AND, MUL…REMU, PASSB).
  - State enum `exec_state_t` (IDLE, MUL, DIV, FIN).
- Sub-module `alu_op_decoder`: combinational ALUOp/funct3/funct7/op5 → `alu_op_t`, with the `ENABLE_M` gate. Instantiated once; the top holds the datapath, FSM and counter.

## Test plan
- ALUOp=10, funct3=000, op5=1, funct7_5=1, a=7, b=9 → next cycle `out_valid`=1, result=0xFFFFFFFE, lt=1, ltu=1, zero=0.
- funct3=101, op5=0, funct7_5=1 (SRAI), a=0x80000000, b=4 → result=0xF8000000. Same with funct7_5=0 (SRLI) → result=0x08000000.
- MULH a=0xFFFFFFFF (−1), b=2 → `in_ready` low 33 cycles; `out_valid` 34 cycles after accept; result=0xFFFFFFFF. MUL, same operands → result=0xFFFFFFFE.
- DIV a=−7, b=2 → result=0xFFFFFFFD (−3). REM → result=0xFFFFFFFF (−1). DIVU by b=0 → 1-cycle result=0xFFFFFFFF. REM a=0x80000000, b=−1 → 1-cycle result=0.
- Start DIVU; drop `rst_n` for one edge at iteration 10 → no `out_valid`, result=0, `in_ready`=1 the cycle after `rst_n` returns high. Then an ADD 3+4 → result=7.
- Back-to-back ADD, SUB, AND on consecutive cycles → three consecutive `out_valid` pulses with correct results. `ENABLE_M`=0, funct7_0=1, funct3=000 → plain ADD in 1 cycle.
